// File: rtl/node_pkg.sv
// Shared types for the endpoint<->router byte link.
//   pkt_t      : 32-bit packet {sourceID, destID, data}
//   rx_state_t : receive FSM states of the router input port
//   PKT_BYTES  : serialized bytes per packet
package node_pkg;

  localparam int unsigned PKT_BYTES = 4;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned DATA_W    = 24;

  typedef struct packed {
    logic [ID_W-1:0]   sourceID;
    logic [ID_W-1:0]   destID;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/pkt_fifo.sv
// Packet FIFO of pkt_t entries; pop_data shows the head (zero when empty).
// Ports: clk, rst_b (async active-low), push/push_data, pop/pop_data,
//        full, empty, count (0..DEPTH). DEPTH must be a power of 2.
module pkt_fifo
  import node_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  pkt_t          push_data,
  input  logic          pop,
  output pkt_t          pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  pkt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so reset leaves a clean output.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Router-side receiver for one endpoint byte link. Grants free_outbound when a
// FIFO slot can be reserved, reassembles 4 bytes into a pkt_t, buffers it and
// presents the head to the router core on a valid/ready interface.
// Ports: clk, rst_b (async active-low), free_outbound (out), put_outbound,
//        payload_outbound[7:0], pkt_out (pkt_t), pkt_valid, pkt_ready,
//        fifo_full, and err_src when ROUTER_IN_SRC_CHECK_EN is defined.
// Option ROUTER_IN_SRC_CHECK_EN: drop packets whose sourceID != NODE_ID and
// pulse err_src for one cycle.
module router_in_port
  import node_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [3:0]  NODE_ID    = 4'h0
) (
  input  logic       clk,
  input  logic       rst_b,
  output logic       free_outbound,
  input  logic       put_outbound,
  input  logic [7:0] payload_outbound,
  output pkt_t       pkt_out,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       fifo_full
`ifdef ROUTER_IN_SRC_CHECK_EN
  ,
  output logic       err_src
`endif
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SH_W = (PKT_BYTES - 1) * 8;

  rx_state_t       state_q;
  rx_state_t       state_d;
  logic [SH_W-1:0] sh_q;
  logic [SH_W-1:0] sh_d;
  logic            free_q;
  logic            free_d;
  logic            err_q;
  logic            err_d;
  logic            push_c;
  logic            pop_c;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  pkt_t            asm_pkt;
  logic            unused_node_id;

  assign unused_node_id = ^NODE_ID;

  // Byte 3 arrives on the wire while bytes 0..2 sit in the shift register.
  assign asm_pkt = pkt_t'({sh_q, payload_outbound});

  assign pop_c      = pkt_valid && pkt_ready;
  assign count_next = count + CW'(push_c) - CW'(pop_c);

  // Next state, assembly shift, push decision and grant.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    push_c  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (free_q && put_outbound) begin
          state_d = B1;
          sh_d    = {sh_q[SH_W-9:0], payload_outbound};
        end
      end
      B1: begin
        state_d = B2;
        sh_d    = {sh_q[SH_W-9:0], payload_outbound};
      end
      B2: begin
        state_d = B3;
        sh_d    = {sh_q[SH_W-9:0], payload_outbound};
      end
      B3: begin
        state_d = IDLE;
`ifdef ROUTER_IN_SRC_CHECK_EN
        if (asm_pkt.sourceID != NODE_ID) err_d  = 1'b1;
        else                             push_c = 1'b1;
`else
        push_c = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Grant only in IDLE with room for one more packet after this edge.
    free_d = (state_d == IDLE) && (count_next < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      sh_q    <= '0;
      free_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      free_q  <= free_d;
      err_q   <= err_d;
    end
  end

  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_c),
    .push_data (asm_pkt),
    .pop       (pop_c),
    .pop_data  (pkt_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign pkt_valid     = !fifo_empty;
  assign free_outbound = free_q;

`ifdef ROUTER_IN_SRC_CHECK_EN
  assign err_src = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/router_in_port.md
Name: router_in_port

Overview:
- Router-side receiver for the endpoint→router byte link: grants `free_outbound`, accepts 4 serialized bytes, reassembles one `pkt_t`, buffers it.
- Presents buffered packets to the router core on a valid/ready interface.
- Sits directly downstream of the node's outbound serializer; one instance per attached node.

Parameters:
- `FIFO_DEPTH`, 2, packet buffer entries (power of 2, ≥2).
- `NODE_ID`, 4'h0, ID of the attached node (used only by the optional feature).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `free_outbound`  out  1  router→endpoint: a whole packet may be sent.
- `put_outbound`  in  1  endpoint→router: marks byte 0 of a packet.
- `payload_outbound`  in  8  serialized packet byte.
- `pkt_out`  out  32 (`pkt_t`)  head-of-FIFO packet to router core.
- `pkt_valid`  out  1  `pkt_out` holds a valid packet.
- `pkt_ready`  in  1  router core consumes the head when `pkt_valid && pkt_ready`.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` packets.

Behaviour:
- Reset (async, `rst_b`=0):
  - `free_outbound`=0, `pkt_valid`=0, `pkt_out`=0, `fifo_full`=0.
  - FIFO emptied, FSM forced to IDLE, any partial packet discarded.
  - Takes effect mid-packet too.
- Byte order:
  - byte0 = {`sourceID`[3:0], `destID`[3:0]}.
  - byte1 = `data`[23:16], byte2 = `data`[15:8], byte3 = `data`[7:0].
- FSM states and transitions:
  - IDLE → B1 when `free_outbound && put_outbound`; byte0 is captured in that cycle.
  - B1 → B2 → B3: one byte captured unconditionally per cycle; `put_outbound` is ignored.
  - B3 → IDLE: byte3 captured and the assembled packet pushed into the FIFO at that edge.
- `free_outbound` (registered):
  - Equals 1 only in IDLE with a FIFO slot reserved, i.e. (count + in-flight) < `FIFO_DEPTH`.
  - Drops to 0 the cycle after `put_outbound` is accepted.
  - Re-asserts the cycle after the byte3 push if the FIFO is still not full.
  - Also re-asserts when a pop frees a slot while in IDLE.
- `put_outbound` while `free_outbound`=0: ignored (protocol violation, no state change).
- Latency: byte3 sampled at edge N → `pkt_valid`=1 with the new packet after edge N (visible in cycle N+1) when the FIFO was empty. Min 4 cycles link occupancy per packet, one IDLE cycle between packets.
- FIFO:
  - Push only from B3, pop on `pkt_valid && pkt_ready`.
  - Simultaneous push/pop: count unchanged, order preserved.
  - Push can never meet a full FIFO, because the slot is reserved at grant.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Outputs: `pkt_out` and `pkt_valid` are stable while `pkt_valid && !pkt_ready`.

Optional Feature:
- `ROUTER_IN_SRC_CHECK_EN` defined:
  - Adds output `err_src` (1 bit, reset 0).
  - At B3 the packet is discarded (no push, slot released) when `sourceID != NODE_ID`.
  - `err_src` pulses 1 for one cycle after that edge.
- Undefined: no `err_src` port; every packet is pushed regardless of `sourceID`.

Decomposition:
- Shared package `node_pkg`:
  - `pkt_t` struct {`sourceID` 4, `destID` 4, `data` 24}.
  - FSM state enum `rx_state_t` {IDLE, B1, B2, B3}.
  - Byte-count constant `PKT_BYTES`=4.
- Sub-module `pkt_fifo`:
  - Parameterized `pkt_t` FIFO, `DEPTH`, push/pop/full/empty/count.
  - Router_in_port holds the FSM, shift/assembly register and slot reservation.

Test Plan:
- Single packet: after reset `free_outbound`=1; bytes F0,AA,AA,AA on 4 cycles (`put` on first) → `pkt_out`=32'hF0AAAAAA, `pkt_valid`=1 the cycle after byte3; `free` 0 during B1–B3, 1 again after.
- Backpressure: `pkt_ready`=0, send 2 packets 12345678, 9ABCDEF0 → `fifo_full`=1, `free_outbound` stays 0; raise `pkt_ready` → pops in order 12345678 then 9ABCDEF0, `free` returns.
- Simultaneous push/pop: one packet queued, `pkt_ready`=1 on the same edge byte3 of the second lands → count stays 1, `pkt_out`=second packet next cycle.
- Illegal put: assert `put` with 8'h55 while `free_outbound`=0 → no state change, no packet appears.
- Reset mid-packet: deassert `rst_b` after byte1 → all outputs 0; after release a fresh full packet 0F123456 is received intact.
- With `ROUTER_IN_SRC_CHECK_EN`, `NODE_ID`=4'h1: packet 1F000001 pushed; packet 2F000002 dropped, `err_src` pulses once, `pkt_valid` stays 0.
